// File: rtl/ped_accumulator.sv
// ped_accumulator: one tree level of the sphere decoder's partial Euclidean
// distance. Forms the complex residual e = y - sum(R_ij*s_j) from a stream of
// product terms, then adds |e|^2 (rescaled to the input Q format) to the
// parent PED with saturation, and holds the child PED until it is taken.
module ped_accumulator #(
    parameter int WIDTH     = 32,
    parameter int FRAC      = 8,
    parameter int MAX_TERMS = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] y_real,
    input  logic [WIDTH-1:0] y_imag,
    input  logic [WIDTH-1:0] parent_ped,
    input  logic [CNT_W-1:0] n_terms,
    input  logic             term_valid,
    output logic             term_ready,
    input  logic [WIDTH-1:0] term_real,
    input  logic [WIDTH-1:0] term_imag,
    output logic             ped_valid,
    input  logic             ped_ready,
    output logic [WIDTH-1:0] ped_out,
    output logic             ped_sat,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_SQUARE,
        S_OUT
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_r_q, res_r_d;
    logic [WIDTH-1:0] res_i_q, res_i_d;
    logic [WIDTH-1:0] parent_q, parent_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ped_out_q, ped_out_d;
    logic             ped_sat_q, ped_sat_d;

    logic [CNT_W-1:0]          n_clamped;
    logic signed [2*WIDTH-1:0] rr_ext, ri_ext;
    logic signed [2*WIDTH-1:0] sq_r, sq_i;
    logic [2*WIDTH:0]          sq;
    logic [2*WIDTH:0]          inc;
    logic [2*WIDTH+1:0]        sum;
    logic                      sum_sat;

    // Squared magnitude of the residual plus parent PED, kept wide enough
    // that the overflow test sees every carry out of the WIDTH-bit result.
    always_comb begin
        n_clamped = (n_terms > MAX_CNT) ? MAX_CNT : n_terms;
        // Operands are sign-extended to full product width so the 2*WIDTH
        // multiply yields the exact signed square.
        rr_ext    = {{WIDTH{res_r_q[WIDTH-1]}}, res_r_q};
        ri_ext    = {{WIDTH{res_i_q[WIDTH-1]}}, res_i_q};
        sq_r      = rr_ext * rr_ext;
        sq_i      = ri_ext * ri_ext;
        sq        = {1'b0, sq_r} + {1'b0, sq_i};
        inc       = sq >> FRAC;
        sum       = {{(WIDTH + 2){1'b0}}, parent_q} + {1'b0, inc};
        sum_sat   = |sum[2*WIDTH+1:WIDTH];
    end

    // Next-state and handshake outputs for the IDLE/ACCUM/SQUARE/OUT sequence.
    always_comb begin
        state_d    = state_q;
        res_r_d    = res_r_q;
        res_i_d    = res_i_q;
        parent_d   = parent_q;
        cnt_d      = cnt_q;
        ped_out_d  = ped_out_q;
        ped_sat_d  = ped_sat_q;
        term_ready = 1'b0;
        ped_valid  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    res_r_d  = y_real;
                    res_i_d  = y_imag;
                    parent_d = parent_ped;
                    cnt_d    = n_clamped;
                    state_d  = (n_clamped != '0) ? S_ACCUM : S_SQUARE;
                end
            end
            S_ACCUM: begin
                term_ready = 1'b1;
                if (term_valid) begin
                    res_r_d = res_r_q - term_real;
                    res_i_d = res_i_q - term_imag;
                    cnt_d   = cnt_q - ONE_CNT;
                    if (cnt_q == ONE_CNT) begin
                        state_d = S_SQUARE;
                    end
                end
            end
            S_SQUARE: begin
                ped_out_d = sum_sat ? '1 : sum[WIDTH-1:0];
                ped_sat_d = sum_sat;
                state_d   = S_OUT;
            end
            S_OUT: begin
                ped_valid = 1'b1;
                if (ped_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any level in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            res_r_q   <= '0;
            res_i_q   <= '0;
            parent_q  <= '0;
            cnt_q     <= '0;
            ped_out_q <= '0;
            ped_sat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            res_r_q   <= res_r_d;
            res_i_q   <= res_i_d;
            parent_q  <= parent_d;
            cnt_q     <= cnt_d;
            ped_out_q <= ped_out_d;
            ped_sat_q <= ped_sat_d;
        end
    end

    assign ped_out = ped_out_q;
    assign ped_sat = ped_sat_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_ped_accumulator.sv
// Bench for ped_accumulator: directed scenarios plus randomized levels,
// each checked against an arithmetic model of the residual/PED rules.
module tb_ped_accumulator;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] y_real;
    logic [31:0] y_imag;
    logic [31:0] parent_ped;
    logic [3:0]  n_terms;
    logic        term_valid;
    logic        term_ready;
    logic [31:0] term_real;
    logic [31:0] term_imag;
    logic        ped_valid;
    logic        ped_ready;
    logic [31:0] ped_out;
    logic        ped_sat;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int tr [16];
    int ti [16];

    ped_accumulator #(
        .WIDTH    (32),
        .FRAC     (8),
        .MAX_TERMS(8),
        .CNT_W    (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .y_real    (y_real),
        .y_imag    (y_imag),
        .parent_ped(parent_ped),
        .n_terms   (n_terms),
        .term_valid(term_valid),
        .term_ready(term_ready),
        .term_real (term_real),
        .term_imag (term_imag),
        .ped_valid (ped_valid),
        .ped_ready (ped_ready),
        .ped_out   (ped_out),
        .ped_sat   (ped_sat),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Child PED from first principles: 32-bit wrapping residual, exact
    // squared magnitude, truncating rescale, saturating add to the parent.
    function automatic void model(input int yr, input int yi, input logic [31:0] par,
                                  input int neff, output logic [31:0] po, output logic ps);
        int                er;
        int                ei;
        longint unsigned   ar;
        longint unsigned   ai;
        logic [64:0]       sq;
        logic [65:0]       tot;
        er = yr;
        ei = yi;
        for (int k = 0; k < neff; k++) begin
            er -= tr[k];
            ei -= ti[k];
        end
        ar  = (er < 0) ? 64'(-longint'(er)) : 64'(longint'(er));
        ai  = (ei < 0) ? 64'(-longint'(ei)) : 64'(longint'(ei));
        sq  = 65'(ar * ar) + 65'(ai * ai);
        tot = 66'(par) + 66'(sq >> 8);
        ps  = (tot > 66'h0_FFFF_FFFF);
        po  = ps ? 32'hFFFF_FFFF : tot[31:0];
    endfunction

    // One full level: start, feed terms per gap_mode (0 back-to-back,
    // 1 fixed 1,0,0,1,0,1 pattern, 2 random), stall ped_ready, retire.
    task automatic run_txn(input string tag, input int yr, input int yi, input logic [31:0] par,
                           input logic [3:0] n, input int gap_mode, input int rdy_delay,
                           input int exp_lat, input bit mid_start);
        int          neff;
        int          idx;
        int          cyc;
        int          rdy_seen;
        bit          done;
        bit          stable;
        logic [31:0] exp_po;
        logic        exp_ps;
        logic [31:0] held;
        logic [5:0]  pat;
        pat  = 6'b101001;
        neff = (n > 4'd8) ? 8 : int'(n);
        model(yr, yi, par, neff, exp_po, exp_ps);

        @(negedge clk);
        start      = 1'b1;
        y_real     = yr;
        y_imag     = yi;
        parent_ped = par;
        n_terms    = n;
        term_valid = (gap_mode == 0);
        term_real  = 32'h0BAD_0BAD;
        term_imag  = 32'h0BAD_0BAD;
        idx      = 0;
        cyc      = 0;
        rdy_seen = 0;
        done     = 1'b0;
        while (!done && cyc < 300) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = 1'b0;
            if (mid_start && cyc == 2) begin
                start      = 1'b1;
                y_real     = yr + 777;
                y_imag     = yi - 555;
                parent_ped = 32'h0000_1234;
                n_terms    = 4'd1;
            end
            if (term_ready) rdy_seen++;
            if (ped_valid) begin
                done = 1'b1;
            end else begin
                case (gap_mode)
                    0:       term_valid = 1'b1;
                    1:       term_valid = pat[(cyc - 1) % 6];
                    default: term_valid = 1'($urandom_range(0, 1));
                endcase
                term_real = (idx < 16) ? tr[idx] : 0;
                term_imag = (idx < 16) ? ti[idx] : 0;
                if (term_valid && term_ready) idx++;
            end
        end
        start      = 1'b0;
        term_valid = 1'b0;

        check_eq({tag, " ped_valid_seen"}, 64'(done), 64'd1);
        if (exp_lat >= 0) check_eq({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        check_eq({tag, " ped_out"}, 64'(ped_out), 64'(exp_po));
        check_eq({tag, " ped_sat"}, 64'(ped_sat), 64'(exp_ps));
        check_eq({tag, " terms_consumed"}, 64'(idx), 64'(neff));
        if (gap_mode == 0) check_eq({tag, " ready_cycles"}, 64'(rdy_seen), 64'(neff));

        held   = ped_out;
        stable = 1'b1;
        for (int k = 0; k < rdy_delay; k++) begin
            @(negedge clk);
            if (!(ped_valid && ped_out === held && ped_sat === exp_ps)) stable = 1'b0;
        end
        if (rdy_delay > 0) check_eq({tag, " hold_stable"}, 64'(stable), 64'd1);
        ped_ready = 1'b1;
        @(negedge clk);
        ped_ready = 1'b0;
        check_eq({tag, " valid_drop"}, 64'(ped_valid), 64'd0);
        check_eq({tag, " idle_after"}, 64'(busy), 64'd0);
        check_eq({tag, " out_kept"}, 64'(ped_out), 64'(exp_po));
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        y_real     = '0;
        y_imag     = '0;
        parent_ped = '0;
        n_terms    = '0;
        term_valid = 1'b0;
        term_real  = '0;
        term_imag  = '0;
        ped_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset term_ready", 64'(term_ready), 64'd0);
        check_eq("reset ped_valid", 64'(ped_valid), 64'd0);
        check_eq("reset ped_out", 64'(ped_out), 64'd0);
        check_eq("reset ped_sat", 64'(ped_sat), 64'd0);
        check_eq("reset busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: residual (256,0) -> 356, valid in cycle 4
        tr[0] = 256; ti[0] = 0; tr[1] = 0; ti[1] = 256;
        run_txn("T1", 512, 256, 32'd100, 4'd2, 0, 0, 4, 1'b0);

        // T2: no terms, |3-4j|^2 in Q.8
        run_txn("T2", 768, -1024, 32'd0, 4'd0, 0, 1, 2, 1'b0);

        // T3: saturation
        run_txn("T3", 256, 256, 32'hFFFF_FF00, 4'd0, 0, 0, 2, 1'b0);

        // T4: gapped term_valid, consumer stalls 5 cycles
        tr[0] = 100; ti[0] = -300; tr[1] = 2000; ti[1] = 7;
        tr[2] = -45; ti[2] = 512;  tr[3] = 99999; ti[3] = 99999;
        run_txn("T4", 4000, -1500, 32'd12345, 4'd3, 1, 5, -1, 1'b0);

        // T5: reset after 2 of 4 terms
        tr[0] = 10; ti[0] = 20; tr[1] = 30; ti[1] = 40; tr[2] = 50; ti[2] = 60; tr[3] = 70; ti[3] = 80;
        @(negedge clk);
        start = 1'b1; y_real = 1000; y_imag = 1000; parent_ped = 32'd5; n_terms = 4'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            term_valid = 1'b1; term_real = tr[k]; term_imag = ti[k];
            @(posedge clk);
            @(negedge clk);
        end
        term_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("T5 async term_ready", 64'(term_ready), 64'd0);
        check_eq("T5 async busy", 64'(busy), 64'd0);
        check_eq("T5 async ped_out", 64'(ped_out), 64'd0);
        check_eq("T5 async ped_sat", 64'(ped_sat), 64'd0);
        check_eq("T5 async ped_valid", 64'(ped_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("T5 no_valid_after", 64'(ped_valid), 64'd0);
        tr[0] = 256; ti[0] = 0; tr[1] = 0; ti[1] = 256;
        run_txn("T5 rerun", 512, 256, 32'd100, 4'd2, 0, 0, 4, 1'b0);

        // T6: start pulse mid-ACCUM ignored; n_terms=12 clamps to 8
        tr[0] = -3000; ti[0] = 1200; tr[1] = 77; ti[1] = -88; tr[2] = 4096; ti[2] = 0;
        run_txn("T6 mid_start", 9000, -2500, 32'd777, 4'd3, 0, 2, 5, 1'b1);
        for (int k = 0; k < 16; k++) begin
            tr[k] = (k + 1) * 300;
            ti[k] = -(k + 1) * 130;
        end
        run_txn("T6 clamp", 20000, -9000, 32'd42, 4'd12, 0, 0, 10, 1'b0);

        // Randomized levels: small Q.8 values and full-range values (wrap/saturation)
        for (int t = 0; t < 30; t++) begin
            int          yr;
            int          yi;
            logic [31:0] par;
            logic [3:0]  n;
            int          gm;
            int          nf;
            bit          wide;
            wide = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < 16; k++) begin
                tr[k] = wide ? int'($urandom) : int'($urandom_range(0, 8191)) - 4096;
                ti[k] = wide ? int'($urandom) : int'($urandom_range(0, 8191)) - 4096;
            end
            yr  = wide ? int'($urandom) : int'($urandom_range(0, 65535)) - 32768;
            yi  = wide ? int'($urandom) : int'($urandom_range(0, 65535)) - 32768;
            par = ($urandom_range(0, 2) == 0) ? 32'hFFFF_0000 | 32'($urandom_range(0, 65535))
                                              : 32'($urandom_range(0, 1000000));
            n   = 4'($urandom_range(0, 15));
            gm  = ($urandom_range(0, 1) == 0) ? 0 : 2;
            nf  = (n > 4'd8) ? 8 : int'(n);
            run_txn($sformatf("R%0d", t), yr, yi, par, n, gm, int'($urandom_range(0, 3)),
                    (gm == 0) ? nf + 2 : -1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
